// File: rtl/sync_bus_filter.sv
// Multi-channel synchronizer with per-channel stability filter and rise/fall pulses.
// Optional simulation-only macro SYNC_INJECT_METASTABILITY_EN randomizes first-stage samples on input changes.
module sync_bus_filter #(
   parameter int unsigned          NCHANNELS  = 4,
   parameter int unsigned          NSTAGES    = 2,
   parameter int unsigned          FILTER_CNT = 3,
   parameter logic [NCHANNELS-1:0] RST_VAL    = '0
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [NCHANNELS-1:0] i_data_in,
   output logic [NCHANNELS-1:0] o_data_early,
   output logic [NCHANNELS-1:0] o_data_out,
   output logic [NCHANNELS-1:0] o_data_filt,
   output logic [NCHANNELS-1:0] o_rise,
   output logic [NCHANNELS-1:0] o_fall,
   output logic [NCHANNELS-1:0] o_pending
);

   localparam int unsigned   CW       = $clog2(FILTER_CNT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CNT - 1);

   if (NCHANNELS < 1) begin : g_chk_nch
      $error("sync_bus_filter: NCHANNELS must be >= 1");
   end
   if (NSTAGES < 2) begin : g_chk_nst
      $error("sync_bus_filter: NSTAGES must be >= 2");
   end
   if (FILTER_CNT < 1) begin : g_chk_flt
      $error("sync_bus_filter: FILTER_CNT must be >= 1");
   end

   logic [NCHANNELS-1:0] r_stage [NSTAGES];
   logic [NCHANNELS-1:0] r_filt;
   logic [NCHANNELS-1:0] r_rise;
   logic [NCHANNELS-1:0] r_fall;
   logic [CW-1:0]        r_cnt [NCHANNELS];
   logic [NCHANNELS-1:0] w_sync;

`ifdef SYNC_INJECT_METASTABILITY_EN
   logic [NCHANNELS-1:0] r_prev_in;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_prev_in <= RST_VAL;
      end else begin
         r_prev_in <= i_data_in;
      end
   end
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int unsigned k = 0; k < NSTAGES; k++) begin
            r_stage[k] <= RST_VAL;
         end
      end else begin
`ifdef SYNC_INJECT_METASTABILITY_EN
         // A level changing across the sampling edge resolves to an arbitrary value.
         for (int unsigned ch = 0; ch < NCHANNELS; ch++) begin
            if (i_data_in[ch] != r_prev_in[ch]) begin
               r_stage[0][ch] <= 1'($urandom % 2);
            end else begin
               r_stage[0][ch] <= i_data_in[ch];
            end
         end
`else
         r_stage[0] <= i_data_in;
`endif
         for (int unsigned k = 1; k < NSTAGES; k++) begin
            r_stage[k] <= r_stage[k-1];
         end
      end
   end

   assign w_sync       = r_stage[NSTAGES-1];
   assign o_data_out   = w_sync;
   assign o_data_early = r_stage[NSTAGES-2];

   // The counter is cleared on adoption, so it never reaches FILTER_CNT.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_filt <= RST_VAL;
         r_rise <= '0;
         r_fall <= '0;
         for (int unsigned ch = 0; ch < NCHANNELS; ch++) begin
            r_cnt[ch] <= '0;
         end
      end else begin
         r_rise <= '0;
         r_fall <= '0;
         for (int unsigned ch = 0; ch < NCHANNELS; ch++) begin
            if (w_sync[ch] == r_filt[ch]) begin
               r_cnt[ch] <= '0;
            end else if (r_cnt[ch] < CNT_LAST) begin
               r_cnt[ch] <= r_cnt[ch] + 1'b1;
            end else begin
               r_filt[ch] <= w_sync[ch];
               r_rise[ch] <= w_sync[ch];
               r_fall[ch] <= ~w_sync[ch];
               r_cnt[ch]  <= '0;
            end
         end
      end
   end

   always_comb begin
      o_pending = '0;
      for (int unsigned ch = 0; ch < NCHANNELS; ch++) begin
         o_pending[ch] = (r_cnt[ch] != '0);
      end
   end

   assign o_data_filt = r_filt;
   assign o_rise      = r_rise;
   assign o_fall      = r_fall;

endmodule

// File: tb/tb_sync_bus_filter.sv
// Bench for sync_bus_filter: vector table, hand sequences for alternate configs, randomized run vs model.
module tb_sync_bus_filter;

   localparam int NS = 2;
   localparam int FC = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_a, rst_b, rst_c;
   logic [3:0] din_a, din_b, din_c;
   logic [3:0] early_a, out_a, filt_a, rise_a, fall_a, pend_a;
   logic [3:0] early_b, out_b, filt_b, rise_b, fall_b, pend_b;
   logic [3:0] early_c, out_c, filt_c, rise_c, fall_c, pend_c;

   int checks = 0;
   int failures = 0;

   sync_bus_filter #(.NCHANNELS(4), .NSTAGES(2), .FILTER_CNT(3), .RST_VAL(4'b0000)) u_a (
      .i_clk(clk), .i_rst(rst_a), .i_data_in(din_a), .o_data_early(early_a), .o_data_out(out_a),
      .o_data_filt(filt_a), .o_rise(rise_a), .o_fall(fall_a), .o_pending(pend_a));

   sync_bus_filter #(.NCHANNELS(4), .NSTAGES(2), .FILTER_CNT(3), .RST_VAL(4'b1000)) u_b (
      .i_clk(clk), .i_rst(rst_b), .i_data_in(din_b), .o_data_early(early_b), .o_data_out(out_b),
      .o_data_filt(filt_b), .o_rise(rise_b), .o_fall(fall_b), .o_pending(pend_b));

   sync_bus_filter #(.NCHANNELS(4), .NSTAGES(3), .FILTER_CNT(1), .RST_VAL(4'b0000)) u_c (
      .i_clk(clk), .i_rst(rst_c), .i_data_in(din_c), .o_data_early(early_c), .o_data_out(out_c),
      .o_data_filt(filt_c), .o_rise(rise_c), .o_fall(fall_c), .o_pending(pend_c));

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s t=%0t actual=%b expected=%b", name, $time, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic       rst;
      logic [3:0] din, early, out, filt, rise, fall, pend;
   } vec_t;

   function automatic vec_t v(input logic r, input logic [3:0] d, input logic [3:0] e, input logic [3:0] o,
                              input logic [3:0] f, input logic [3:0] ri, input logic [3:0] fa, input logic [3:0] p);
      vec_t x;
      x.rst = r; x.din = d; x.early = e; x.out = o; x.filt = f; x.rise = ri; x.fall = fa; x.pend = p;
      return x;
   endfunction

   // Dut C input: ch0 toggles every 4 cycles, starting high at cycle 0.
   function automatic logic c_in(input int t);
      if (t < 0) return 1'b0;
      return ((t / 4) % 2) == 0;
   endfunction

   // Reference model for dut A: delay line of NS samples, plus the full history of
   // synchronized samples; a channel adopts a new level once its last FC samples, all
   // taken after its previous adoption, disagree with the filtered level.
   logic [3:0] m_pipe[$];
   logic [3:0] m_seen[$];
   int         m_since[4];
   logic [3:0] m_filt, m_rise, m_fall, m_pend;

   task automatic model_step(input logic r, input logic [3:0] d);
      int  n;
      bit  all_diff;
      m_rise = '0;
      m_fall = '0;
      if (r) begin
         m_pipe.delete();
         repeat (NS) m_pipe.push_back(4'b0000);
         m_seen.delete();
         m_filt = 4'b0000;
         for (int ch = 0; ch < 4; ch++) m_since[ch] = 0;
      end else begin
         m_seen.push_back(m_pipe[0]);
         void'(m_pipe.pop_front());
         m_pipe.push_back(d);
         n = m_seen.size() - 1;
         for (int ch = 0; ch < 4; ch++) begin
            if (n - FC + 1 >= m_since[ch]) begin
               all_diff = 1'b1;
               for (int j = n - FC + 1; j <= n; j++)
                  if (m_seen[j][ch] == m_filt[ch]) all_diff = 1'b0;
               if (all_diff) begin
                  m_filt[ch] = ~m_filt[ch];
                  m_rise[ch] = m_filt[ch];
                  m_fall[ch] = ~m_filt[ch];
                  m_since[ch] = n + 1;
               end
            end
         end
      end
      for (int ch = 0; ch < 4; ch++)
         m_pend[ch] = (m_seen.size() > 0) && (m_seen.size() - 1 >= m_since[ch]) &&
                      (m_seen[m_seen.size()-1][ch] != m_filt[ch]);
   endtask

   vec_t tbl[$];

   initial begin
      rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
      din_a = 4'b0000; din_b = 4'b1000; din_c = 4'b0000;

`ifdef SYNC_INJECT_METASTABILITY_EN
      begin
         logic v0;
         int   pulses;
         tick();
         rst_a = 1'b0;
         v0 = 1'b0;
         repeat (3) tick();
         for (int k = 0; k < 100; k++) begin
            v0 = ~v0;
            din_a = {3'b000, v0};
            pulses = 0;
            repeat (10) begin
               tick();
               pulses += int'(rise_a[0]) + int'(fall_a[0]);
            end
            chk($sformatf("meta%0d_filt", k), {3'b000, filt_a[0]}, {3'b000, v0});
            chk($sformatf("meta%0d_pulses", k), 4'(pulses), 4'd1);
         end
      end
`else
      // Single-channel rise, 2- and 3-cycle excursions on ch1, reset mid-count.
      tbl.push_back(v(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
      tbl.push_back(v(0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
      tbl.push_back(v(0, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
      tbl.push_back(v(0, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001));
      tbl.push_back(v(0, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001));
      tbl.push_back(v(0, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000));
      tbl.push_back(v(0, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000));
      tbl.push_back(v(0, 4'b0011, 4'b0011, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000));
      tbl.push_back(v(0, 4'b0011, 4'b0011, 4'b0011, 4'b0001, 4'b0000, 4'b0000, 4'b0000));
      tbl.push_back(v(0, 4'b0001, 4'b0001, 4'b0011, 4'b0001, 4'b0000, 4'b0000, 4'b0010));
      tbl.push_back(v(0, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0010));
      tbl.push_back(v(0, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000));
      tbl.push_back(v(0, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000));
      tbl.push_back(v(0, 4'b0011, 4'b0011, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000));
      tbl.push_back(v(0, 4'b0011, 4'b0011, 4'b0011, 4'b0001, 4'b0000, 4'b0000, 4'b0000));
      tbl.push_back(v(0, 4'b0011, 4'b0011, 4'b0011, 4'b0001, 4'b0000, 4'b0000, 4'b0010));
      tbl.push_back(v(0, 4'b0001, 4'b0001, 4'b0011, 4'b0001, 4'b0000, 4'b0000, 4'b0010));
      tbl.push_back(v(0, 4'b0001, 4'b0001, 4'b0001, 4'b0011, 4'b0010, 4'b0000, 4'b0000));
      tbl.push_back(v(0, 4'b0001, 4'b0001, 4'b0001, 4'b0011, 4'b0000, 4'b0000, 4'b0010));
      tbl.push_back(v(0, 4'b0001, 4'b0001, 4'b0001, 4'b0011, 4'b0000, 4'b0000, 4'b0010));
      tbl.push_back(v(0, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0000));
      tbl.push_back(v(0, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000));
      tbl.push_back(v(1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
      tbl.push_back(v(0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
      tbl.push_back(v(0, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
      tbl.push_back(v(0, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001));
      tbl.push_back(v(1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
      tbl.push_back(v(0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
      tbl.push_back(v(0, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000));
      tbl.push_back(v(0, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001));
      tbl.push_back(v(0, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001));
      tbl.push_back(v(0, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000));
      tbl.push_back(v(0, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000));

      for (int i = 0; i < tbl.size(); i++) begin
         rst_a = tbl[i].rst;
         din_a = tbl[i].din;
         tick();
         chk($sformatf("row%0d_early", i), early_a, tbl[i].early);
         chk($sformatf("row%0d_out", i), out_a, tbl[i].out);
         chk($sformatf("row%0d_filt", i), filt_a, tbl[i].filt);
         chk($sformatf("row%0d_rise", i), rise_a, tbl[i].rise);
         chk($sformatf("row%0d_fall", i), fall_a, tbl[i].fall);
         chk($sformatf("row%0d_pend", i), pend_a, tbl[i].pend);
      end

      // Nonzero reset value; simultaneous rise on ch2 and fall on ch3.
      chk("b_rst_out", out_b, 4'b1000);
      chk("b_rst_early", early_b, 4'b1000);
      chk("b_rst_filt", filt_b, 4'b1000);
      rst_b = 1'b0;
      repeat (2) tick();
      chk("b_idle_filt", filt_b, 4'b1000);
      din_b = 4'b0100;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk($sformatf("b%0d_filt", i), filt_b, (i >= 4) ? 4'b0100 : 4'b1000);
         chk($sformatf("b%0d_rise", i), rise_b, (i == 4) ? 4'b0100 : 4'b0000);
         chk($sformatf("b%0d_fall", i), fall_b, (i == 4) ? 4'b1000 : 4'b0000);
      end

      // Deep chain, no glitch filtering: 4-edge latency and a pulse per toggle.
      rst_c = 1'b0;
      for (int t = 0; t < 32; t++) begin
         din_c = {3'b000, c_in(t)};
         tick();
         chk($sformatf("c%0d_out", t), out_c, {3'b000, c_in(t-2)});
         chk($sformatf("c%0d_filt", t), filt_c, {3'b000, c_in(t-3)});
         chk($sformatf("c%0d_rise", t), rise_c, {3'b000, c_in(t-3) & ~c_in(t-4)});
         chk($sformatf("c%0d_fall", t), fall_c, {3'b000, ~c_in(t-3) & c_in(t-4)});
         chk($sformatf("c%0d_pend", t), pend_c, 4'b0000);
      end

      // Randomized run against the model, with occasional resets.
      rst_a = 1'b1;
      din_a = 4'($urandom);
      for (int cyc = 0; cyc < 800; cyc++) begin
         tick();
         model_step(rst_a, din_a);
         chk($sformatf("r%0d_early", cyc), early_a, m_pipe[NS-1]);
         chk($sformatf("r%0d_out", cyc), out_a, m_pipe[0]);
         chk($sformatf("r%0d_filt", cyc), filt_a, m_filt);
         chk($sformatf("r%0d_rise", cyc), rise_a, m_rise);
         chk($sformatf("r%0d_fall", cyc), fall_a, m_fall);
         chk($sformatf("r%0d_pend", cyc), pend_a, m_pend);
         rst_a = ($urandom_range(0, 79) == 0);
         for (int ch = 0; ch < 4; ch++)
            if ($urandom_range(0, 5) < ((cyc / 100) % 3 + 1)) din_a[ch] = ~din_a[ch];
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
